// File: rtl/spike_pop_counter.sv
// Population spike counter: counts spikes from a time-multiplexed neuron pool over WIN sweeps
// and presents the registered, saturated count to the EMG synthesis stage.
module spike_pop_counter #(
    parameter int unsigned NN   = 8,
    parameter int unsigned WIN  = 1,
    parameter bit          HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_spike,
    input  logic        i_valid,
    input  logic        i_sync,
    output logic [NN:0] o_spk_cnt,
    output logic        o_cnt_valid,
    output logic        o_sync_err
);

    localparam int unsigned CW = NN + 1;
    localparam int unsigned AW = NN + 5;
    localparam logic [NN:0] IdxLast = {CW{1'b1}};
    localparam logic [NN:0] IdxOne  = CW'(1);
    localparam logic [3:0]  SwpLast = 4'(WIN - 1);
    localparam logic [AW:0] SatMax  = {{5{1'b0}}, {CW{1'b1}}};

    typedef enum logic {
        StWaitSync,
        StRun
    } state_e;

    state_e        state_q, state_d;
    logic [NN:0]   idx_q, idx_d;
    logic [3:0]    swp_q, swp_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [NN:0]   cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;

    // One bit wider than acc: a full 16-sweep window plus the closing spike reaches 2^AW.
    logic [AW:0]   acc_sum;
    logic          close_win;

    always_comb begin
        acc_sum   = {1'b0, acc_q} + {{AW{1'b0}}, i_spike};
        close_win = (idx_q == IdxLast) && (swp_q == SwpLast);

        state_d = state_q;
        idx_d   = idx_q;
        swp_d   = swp_q;
        acc_d   = acc_q;
        cnt_d   = HOLD ? cnt_q : '0;
        vld_d   = 1'b0;
        err_d   = 1'b0;

        if (i_valid) begin
            case (state_q)
                StWaitSync: begin
                    if (i_sync) begin
                        state_d = StRun;
                        idx_d   = IdxOne;
                        swp_d   = 4'd0;
                        acc_d   = {{(AW-1){1'b0}}, i_spike};
                    end
                end
                StRun: begin
                    if (i_sync && (idx_q != '0)) begin
                        // Mis-timed sync: this beat becomes neuron 0 of a fresh window.
                        err_d = 1'b1;
                        idx_d = IdxOne;
                        swp_d = 4'd0;
                        acc_d = {{(AW-1){1'b0}}, i_spike};
                    end else if (close_win) begin
                        vld_d = 1'b1;
                        cnt_d = (acc_sum > SatMax) ? IdxLast : acc_sum[NN:0];
                        acc_d = '0;
                        idx_d = '0;
                        swp_d = 4'd0;
                    end else begin
                        acc_d = acc_sum[AW-1:0];
                        idx_d = idx_q + IdxOne;
                        if (idx_q == IdxLast) begin
                            swp_d = swp_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = StWaitSync;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWaitSync;
            idx_q   <= '0;
            swp_q   <= 4'd0;
            acc_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            swp_q   <= swp_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign o_spk_cnt   = cnt_q;
    assign o_cnt_valid = vld_q;
    assign o_sync_err  = err_q;

endmodule

// File: tb/tb_spike_pop_counter.sv
// Self-checking bench: two counters (WIN=1 impulse, WIN=2 hold) share one directed stimulus
// and are compared every cycle against a window-position model plus literal pulse tables.
module tb_spike_pop_counter;

    localparam int P = 8;

    typedef struct packed {
        bit synced;
        int pos;
        int sum;
        int cnt;
        bit vld;
        bit err;
    } model_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_spike = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_sync = 1'b0;
    logic [2:0] a_cnt, b_cnt;
    logic       a_vld, b_vld, a_err, b_err;
    bit         done = 1'b0;

    model_t ma, mb;

    always #5 clk = ~clk;

    spike_pop_counter #(.NN(2), .WIN(1), .HOLD(1'b0)) dut_a (
        .clk(clk), .reset(reset), .i_spike(i_spike), .i_valid(i_valid), .i_sync(i_sync),
        .o_spk_cnt(a_cnt), .o_cnt_valid(a_vld), .o_sync_err(a_err)
    );

    spike_pop_counter #(.NN(2), .WIN(2), .HOLD(1'b1)) dut_b (
        .clk(clk), .reset(reset), .i_spike(i_spike), .i_valid(i_valid), .i_sync(i_sync),
        .o_spk_cnt(b_cnt), .o_cnt_valid(b_vld), .o_sync_err(b_err)
    );

    // pos is the beat offset inside the current window; a sync is legal only on a sweep start.
    function automatic model_t step(model_t m, bit v, bit s, bit sp, int win, bit hold);
        model_t n = m;
        n.vld = 1'b0;
        n.err = 1'b0;
        if (!hold) n.cnt = 0;
        if (v) begin
            if (!m.synced) begin
                if (s) begin
                    n.synced = 1'b1;
                    n.pos = 1;
                    n.sum = int'(sp);
                end
            end else if (s && (m.pos % P) != 0) begin
                n.err = 1'b1;
                n.pos = 1;
                n.sum = int'(sp);
            end else begin
                n.sum = m.sum + int'(sp);
                if (m.pos == P * win - 1) begin
                    n.vld = 1'b1;
                    n.cnt = (n.sum > P - 1) ? P - 1 : n.sum;
                    n.pos = 0;
                    n.sum = 0;
                end else begin
                    n.pos = m.pos + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, i_valid, i_sync, i_spike, 1, 1'b0);
            mb <= step(mb, i_valid, i_sync, i_spike, 2, 1'b1);
        end
    end

    // Hand-computed window results in order of appearance.
    int lit_a [9] = '{5, 5, 7, 7, 1, 4, 0, 5, 0};
    int lit_b [4] = '{7, 7, 4, 5};

    int checks = 0;
    int errors = 0;
    int na = 0, nb = 0, ea = 0, eb = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                chk("a_pulse_count", na, 9);
                chk("b_pulse_count", nb, 4);
                chk("a_err_count", ea, 1);
                chk("b_err_count", eb, 1);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            chk("a_cnt", int'(a_cnt), ma.cnt);
            chk("a_vld", int'(a_vld), int'(ma.vld));
            chk("a_err", int'(a_err), int'(ma.err));
            chk("b_cnt", int'(b_cnt), mb.cnt);
            chk("b_vld", int'(b_vld), int'(mb.vld));
            chk("b_err", int'(b_err), int'(mb.err));
            if (a_vld && a_err) chk("a_vld_err_overlap", 1, 0);
            if (b_vld && b_err) chk("b_vld_err_overlap", 1, 0);
            if (a_vld) begin
                if (na < 9) chk("a_literal", int'(a_cnt), lit_a[na]);
                else chk("a_extra_pulse", na, 8);
                na++;
            end
            if (b_vld) begin
                if (nb < 4) chk("b_literal", int'(b_cnt), lit_b[nb]);
                else chk("b_extra_pulse", nb, 3);
                nb++;
            end
            if (a_err) ea++;
            if (b_err) eb++;
        end
    end

    task automatic beat(input bit v, input bit s, input bit sp);
        @(posedge clk);
        #1;
        i_valid = v;
        i_sync  = s;
        i_spike = sp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        i_valid = 1'b0;
        i_sync  = 1'b0;
        i_spike = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Spikes are taken MSB first; gaps insert ignored beats carrying sync/spike high.
    task automatic sweep(input logic [7:0] pat, input int nbeats, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            beat(1'b1, i == 0, pat[7-i]);
            if (gaps && (i % 2 == 1)) beat(1'b0, 1'b1, 1'b1);
        end
    endtask

    initial begin
        #23 reset = 1'b0;
        idle(20);

        sweep(8'b10110011, 8, 1'b0);
        sweep(8'b10110011, 8, 1'b1);
        idle(3);

        do_reset();
        sweep(8'b11111111, 8, 1'b0);
        sweep(8'b11111111, 8, 1'b0);
        idle(3);

        do_reset();
        sweep(8'b00000001, 8, 1'b0);
        idle(3);

        do_reset();
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        sweep(8'b00000000, 8, 1'b0);
        idle(3);

        do_reset();
        sweep(8'b11010000, 5, 1'b0);
        do_reset();
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        sweep(8'b10110011, 8, 1'b0);
        sweep(8'b00000000, 8, 1'b0);
        idle(4);

        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
